inst_encoder: RTL and testbench

Instruction encoder and program loader: the write-side counterpart of the instruction decoder. It takes instruction fields (opcode, three register addresses, 16-bit address) over a valid/ready handshake, packs them into the 32-bit instruction format and buffers them in a small FIFO. It then writes the words into instruction memory at consecutive addresses. It sits between the test/boot program source and the instruction memory that the multi-cycle processor fetches from.

---
 rtl/isa_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/inst_encoder.sv | 145 ++++++++++++++
 tb/tb_inst_encoder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: instruction-format constants shared by the encoder and the decoder.
//   - Field MSB positions inside the 32-bit instruction word.
//   - Encoder FSM state type.
//   - encode_insn(): packs one field tuple into an instruction word.
package isa_pkg;

    localparam int INSN_W   = 32;
    localparam int OPC_W    = 3;
    localparam int REG_W    = 5;
    localparam int ADDR_W   = 16;

    localparam int OPC_MSB  = 31;
    localparam int R0_MSB   = 28;
    localparam int R1_MSB   = 23;
    localparam int R2_MSB   = 18;
    localparam int ADDR_MSB = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_e;

    // Address format leaves [18:16] zero. The decoder's reg_addr_2 field then
    // reads {3'b000, addr[15:14]}; that overlap is part of the format.
    function automatic logic [INSN_W-1:0] encode_insn(
        input logic [OPC_W-1:0]  op,
        input logic [REG_W-1:0]  r0,
        input logic [REG_W-1:0]  r1,
        input logic [REG_W-1:0]  r2,
        input logic [ADDR_W-1:0] a,
        input logic              use_addr
    );
        logic [INSN_W-1:0] w;
        w = '0;
        w[OPC_MSB -: OPC_W] = op;
        w[R0_MSB  -: REG_W] = r0;
        w[R1_MSB  -: REG_W] = r1;
        if (use_addr) begin
            w[ADDR_MSB -: ADDR_W] = a;
        end else begin
            w[R2_MSB -: REG_W] = r2;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage (no write-to-read bypass).
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset; empties the FIFO
//   flush_i  synchronous flush; empties the FIFO, wins over push/pop
//   push_i   write wdata_i (ignored when full)
//   pop_i    drop the head entry (ignored when empty)
//   wdata_i  write data
//   rdata_o  head entry (valid when !empty_o)
//   full_o   DEPTH entries stored
//   empty_o  no entries stored
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_MAX = DEPTH[PW:0];

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_MAX);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible after it was pushed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs instruction field tuples into 32-bit words, buffers them
// in a FIFO and writes them to instruction memory at consecutive addresses.
//   clk, rst            clock, synchronous active-high reset
//   start, base_addr    (re)load write pointer, clear count/overflow, enter RUN
//   in_valid/in_ready   field-tuple handshake
//   opcode, reg_addr_*, addr, use_addr   instruction fields
//   mem_we/mem_ready    memory write handshake; mem_addr/mem_wdata write payload
//   count               words written since the last start
//   busy                not IDLE, or words still queued
//   overflow            sticky: last memory word was written
module inst_encoder import isa_pkg::*; #(
    parameter int IMEM_AW    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IMEM_AW-1:0] base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [4:0]         reg_addr_0,
    input  logic [4:0]         reg_addr_1,
    input  logic [4:0]         reg_addr_2,
    input  logic [15:0]        addr,
    input  logic               use_addr,
    output logic               mem_we,
    output logic [IMEM_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ready,
    output logic [IMEM_AW:0]   count,
    output logic               busy,
    output logic               overflow
);

    localparam logic [IMEM_AW-1:0] PTR_ONE  = {{(IMEM_AW-1){1'b0}}, 1'b1};
    localparam logic [IMEM_AW-1:0] PTR_LAST = {IMEM_AW{1'b1}};
    localparam logic [IMEM_AW:0]   CNT_ONE  = {{IMEM_AW{1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [IMEM_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IMEM_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [INSN_W-1:0]  enc_word;
    logic [INSN_W-1:0]  fifo_head;
    logic               fifo_full, fifo_empty;
    logic               fifo_push, fifo_pop, fifo_flush;
    logic               last_write;

    assign enc_word   = encode_insn(opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr, use_addr);

    // in_ready is purely registered; a start in the same cycle still blocks
    // the push so a restart never carries a tuple over.
    assign fifo_push  = in_valid && in_ready && !start;
    assign fifo_pop   = mem_we && mem_ready;
    assign last_write = fifo_pop && (wr_ptr_q == PTR_LAST);
    // Whatever is still queued after the last memory word has nowhere to go.
    assign fifo_flush = start || last_write;

    sync_fifo #(
        .WIDTH (INSN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (enc_word),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (start)           state_d = RUN;
                else if (last_write) state_d = FULL;
            end
            FULL:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Pointer, count and overflow next values
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (start) begin
            wr_ptr_d   = base_addr;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (fifo_pop) begin
            // Pointer wraps to 0 on the last word; FULL stops further writes.
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
            if (last_write) overflow_d = 1'b1;
        end
    end

    // FSM outputs. mem_we is held off in a start cycle so a restart never
    // lets an old queued word reach memory.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            RUN: begin
                in_ready = !fifo_full;
                mem_we   = !fifo_empty && !start;
            end
            default: begin
                in_ready = 1'b0;
                mem_we   = 1'b0;
            end
        endcase
    end

    assign mem_addr  = wr_ptr_q;
    assign mem_wdata = mem_we ? fifo_head : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    opcode;
    logic [4:0]    reg_addr_0, reg_addr_1, reg_addr_2;
    logic [15:0]   addr;
    logic          use_addr;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [AW:0]   count;
    logic          busy;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Every completed memory write, as {address, data}.
    logic [AW+31:0] wq[$];

    inst_encoder #(.IMEM_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .reg_addr_0 (reg_addr_0),
        .reg_addr_1 (reg_addr_1),
        .reg_addr_2 (reg_addr_2),
        .addr       (addr),
        .use_addr   (use_addr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .count      (count),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) wq.push_back({mem_addr, mem_wdata});
    end

    // Reference encoding from the field placement rules, plain arithmetic.
    function automatic logic [31:0] ref_enc(input int op, input int r0, input int r1,
                                            input int r2, input int a, input bit ua);
        longint w;
        w = (longint'(op) << 29) + (longint'(r0) << 24) + (longint'(r1) << 19)
          + (ua ? longint'(a) : (longint'(r2) << 14));
        return w[31:0];
    endfunction

    function automatic logic [31:0] cur_enc();
        return ref_enc(opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr, use_addr);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_tuple();
        opcode     = 3'($urandom);
        reg_addr_0 = 5'($urandom);
        reg_addr_1 = 5'($urandom);
        reg_addr_2 = 5'($urandom);
        addr       = 16'($urandom);
        use_addr   = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1; base_addr = '0;
        rand_tuple();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        base_addr = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, count, busy, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b mem_we=%b mem_addr=%h mem_wdata=%h count=%0d busy=%b overflow=%b, want all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, count, busy, overflow);
        end
        in_valid = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_valid: in_ready=%b busy=%b mem_we=%b, want 0 0 0", in_ready, busy, mem_we);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_register_format();
        do_reset();
        pulse_start(8'h10);
        wq.delete();
        opcode = 3'b101; reg_addr_0 = 5'd1; reg_addr_1 = 5'd2; reg_addr_2 = 5'd3;
        addr = 16'h5A5A; use_addr = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 32'hA110C000) begin
            errors++;
            $display("FAIL reg_format_write: we=%b addr=%h data=%h, want 1 10 a110c000", mem_we, mem_addr, mem_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (count !== 9'd1 || mem_we !== 1'b0 || wq.size() != 1) begin
            errors++;
            $display("FAIL reg_format_done: count=%0d we=%b writes=%0d, want 1 0 1", count, mem_we, wq.size());
        end
    endtask

    task automatic test_addr_format();
        opcode = 3'b011; reg_addr_0 = 5'd31; reg_addr_1 = 5'd0; reg_addr_2 = 5'($urandom);
        addr = 16'hBEEF; use_addr = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h11 || mem_wdata !== 32'h7F00BEEF) begin
            errors++;
            $display("FAIL addr_format_write: we=%b addr=%h data=%h, want 1 11 7f00beef", mem_we, mem_addr, mem_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (count !== 9'd2) begin
            errors++;
            $display("FAIL addr_format_count: got %0d want 2", count);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0]    exp[$];
        logic [AW-1:0]  b;
        logic [AW+31:0] hold;
        bit             have_hold, stable, acc_now;
        int             acc;
        exp.delete(); have_hold = 0; stable = 1; acc = 0; hold = '0;
        do_reset();
        b = AW'($urandom_range(32, 128));
        pulse_start(b);
        mem_ready = 1'b0;
        rand_tuple();
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc_now = 0;
            if (mem_we) begin
                if (!have_hold) begin hold = {mem_addr, mem_wdata}; have_hold = 1; end
                else if ({mem_addr, mem_wdata} !== hold) stable = 0;
            end
            if (in_valid && in_ready) begin exp.push_back(cur_enc()); acc++; acc_now = 1; end
            tick();
            if (acc_now) rand_tuple();
        end
        @(negedge clk);
        checks++;
        if (acc != DEPTH || in_ready !== 1'b0 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: accepted=%0d in_ready=%b we=%b, want %0d 0 1", acc, in_ready, mem_we, DEPTH);
        end
        checks++;
        if (!stable || !have_hold || hold !== {b, exp[0]}) begin
            errors++;
            $display("FAIL bp_hold_stable: stable=%0d held=%h want %h", stable, hold, {b, exp[0]});
        end
        in_valid = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) #1;
            else @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(b + i) || mem_wdata !== exp[i]) begin
                errors++;
                $display("FAIL bp_drain[%0d]: we=%b addr=%h data=%h, want 1 %h %h",
                         i, mem_we, mem_addr, mem_wdata, AW'(b + i), exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || count !== 9'(DEPTH)) begin
            errors++;
            $display("FAIL bp_done: we=%b count=%0d, want 0 %0d", mem_we, count, DEPTH);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp[$];
        int          acc;
        bit          acc_now;
        exp.delete(); acc = 0;
        do_reset();
        pulse_start(8'hFE);
        wq.delete();
        rand_tuple();
        in_valid = 1'b1;
        for (int c = 0; c < 8 && acc < 3; c++) begin
            @(negedge clk);
            acc_now = 0;
            if (in_ready) begin exp.push_back(cur_enc()); acc++; acc_now = 1; end
            tick();
            if (acc_now) rand_tuple();
        end
        tick();
        @(negedge clk);
        checks++;
        if (acc != 3 || overflow !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0
            || count !== 9'd2 || busy !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL wrap_full: acc=%0d ovf=%b in_ready=%b we=%b count=%0d busy=%b addr=%h, want 3 1 0 0 2 1 00",
                     acc, overflow, in_ready, mem_we, count, busy, mem_addr);
        end
        tick();
        tick();
        checks++;
        if (wq.size() != 2 || wq[0] !== {8'hFE, exp[0]} || wq[1] !== {8'hFF, exp[1]}) begin
            errors++;
            $display("FAIL wrap_writes: n=%0d w0=%h w1=%h, want 2 %h %h",
                     wq.size(), wq[0], wq[1], {8'hFE, exp[0]}, {8'hFF, exp[1]});
        end
        in_valid = 1'b0;
        pulse_start(8'h40);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || count !== 9'd0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL wrap_restart: ovf=%b count=%0d in_ready=%b we=%b, want 0 0 1 0",
                     overflow, count, in_ready, mem_we);
        end
    endtask

    task automatic test_start_midop();
        do_reset();
        pulse_start(8'h30);
        mem_ready = 1'b0;
        rand_tuple(); in_valid = 1'b1;
        tick();
        rand_tuple();
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h30) begin
            errors++;
            $display("FAIL restart_pre: we=%b addr=%h, want 1 30", mem_we, mem_addr);
        end
        wq.delete();
        start = 1'b1; base_addr = 8'h50; mem_ready = 1'b1;
        rand_tuple(); in_valid = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL restart_no_write: we=%b want 0", mem_we);
        end
        tick();
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 9'd0 || mem_we !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1 || mem_addr !== 8'h50) begin
            errors++;
            $display("FAIL restart_state: count=%0d we=%b busy=%b in_ready=%b addr=%h, want 0 0 1 1 50",
                     count, mem_we, busy, in_ready, mem_addr);
        end
        repeat (3) tick();
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL restart_stale: writes=%0d want 0", wq.size());
        end
        rand_tuple(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h50 || mem_wdata !== cur_enc()) begin
            errors++;
            $display("FAIL restart_first: we=%b addr=%h data=%h, want 1 50 %h", mem_we, mem_addr, mem_wdata, cur_enc());
        end
    endtask

    task automatic test_reset_midop();
        pulse_start(8'h60);
        mem_ready = 1'b0;
        rand_tuple(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: we=%b want 1", mem_we);
        end
        rst = 1'b1; start = 1'b1; base_addr = 8'h99; mem_ready = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, count, busy, overflow} !== '0) begin
            errors++;
            $display("FAIL rst_mid_state: in_ready=%b we=%b addr=%h data=%h count=%0d busy=%b ovf=%b, want all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, count, busy, overflow);
        end
    endtask

    task automatic test_random();
        logic [31:0]   exp[$];
        logic [AW-1:0] b;
        int            occ;
        bit            acc, wr, bad;
        for (int it = 0; it < 4; it++) begin
            exp.delete(); occ = 0; bad = 0;
            do_reset();
            b = AW'($urandom_range(0, 100));
            pulse_start(b);
            wq.delete();
            for (int c = 0; c < 60; c++) begin
                rand_tuple();
                in_valid  = ($urandom_range(0, 3) != 0);
                mem_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (in_ready !== (occ < DEPTH) || mem_we !== (occ > 0)) bad = 1;
                acc = in_valid && (occ < DEPTH);
                wr  = mem_ready && (occ > 0);
                if (acc) exp.push_back(cur_enc());
                occ = occ + int'(acc) - int'(wr);
                tick();
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL rand_handshake[%0d]: in_ready/mem_we deviated from occupancy model", it);
            end
            in_valid = 1'b0; mem_ready = 1'b1;
            repeat (DEPTH + 2) tick();
            checks++;
            if (count !== 9'(exp.size()) || wq.size() != exp.size()) begin
                errors++;
                $display("FAIL rand_count[%0d]: count=%0d writes=%0d want %0d", it, count, wq.size(), exp.size());
            end
            bad = 0;
            for (int i = 0; i < exp.size() && i < wq.size(); i++)
                if (wq[i] !== {AW'(b + i), exp[i]}) bad = 1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL rand_data[%0d]: write sequence differs from accepted tuples at base %h", it, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_register_format();
        test_addr_format();
        test_back_pressure();
        test_wrap();
        test_start_midop();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
